// File: rtl/memoria_pkg.sv
// Shared definitions for the main-memory responder: FSM states and default geometry.
package memoria_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESCRITA  = 2'd1,
    LEITURA  = 2'd2,
    RESPOSTA = 2'd3
  } estado_t;

  localparam int ADDR_W          = 5;
  localparam int DATA_W          = 8;
  localparam int LATENCIA_PADRAO = 3;

endpackage

// File: rtl/banco_memoria.sv
// Backing array: synchronous write, combinational read, reset loads mem[i] = i.
module banco_memoria #(
  parameter int ADDR_W = memoria_pkg::ADDR_W,
  parameter int DATA_W = memoria_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              escrita_habilitada,
  input  logic [ADDR_W-1:0] endereco_escrita,
  input  logic [DATA_W-1:0] dado_escrita,
  input  logic [ADDR_W-1:0] endereco_leitura,
  output logic [DATA_W-1:0] dado_leitura
);

  localparam int PROFUNDIDADE = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [PROFUNDIDADE];

  // Array update: reset wins over a coincident write so an aborted write-back never lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        mem_r[i] <= DATA_W'(i);
      end
    end else if (escrita_habilitada) begin
      mem_r[endereco_escrita] <= dado_escrita;
    end
  end

  assign dado_leitura = mem_r[endereco_leitura];

endmodule

// File: rtl/memoria_principal.sv
// Main-memory responder for the cache: fixed-latency write-back and block fill,
// write-back always committed before the fill of a combined request.
module memoria_principal #(
  parameter int LATENCY = memoria_pkg::LATENCIA_PADRAO,
  parameter int ADDR_W  = memoria_pkg::ADDR_W,
  parameter int DATA_W  = memoria_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              solicitacao_de_leitura_na_memoria,
  input  logic              solicitacao_de_escrita_na_memoria,
  input  logic [ADDR_W-1:0] tag_de_acesso_na_memoria,
  input  logic [ADDR_W-1:0] endereco_de_escrita_na_memoria,
  input  logic [DATA_W-1:0] bloco_a_ser_escrito_na_memoria,
  output logic [DATA_W-1:0] bloco_lido_da_memoria,
  output logic              pronto,
  output logic              ocupado
);

  import memoria_pkg::*;

  localparam logic [3:0] RECARGA = 4'(LATENCY - 1);

  estado_t           estado_r;
  logic [3:0]        contador_r;
  logic              pendente_r;
  logic [ADDR_W-1:0] endereco_escrita_r;
  logic [DATA_W-1:0] dado_escrita_r;
  logic [ADDR_W-1:0] endereco_leitura_r;
  logic [DATA_W-1:0] bloco_r;
  logic              pronto_r;
  logic              ocupado_r;
  logic              escrita_habilitada_s;
  logic [DATA_W-1:0] dado_lido_s;

  assign escrita_habilitada_s = (estado_r == ESCRITA) && (contador_r == 4'd0);

  banco_memoria #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_banco (
    .clock             (clock),
    .reset             (reset),
    .escrita_habilitada(escrita_habilitada_s),
    .endereco_escrita  (endereco_escrita_r),
    .dado_escrita      (dado_escrita_r),
    .endereco_leitura  (endereco_leitura_r),
    .dado_leitura      (dado_lido_s)
  );

  // Access FSM: requests are sampled only in OCIOSO, pronto and ocupado are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r           <= OCIOSO;
      contador_r         <= 4'd0;
      pendente_r         <= 1'b0;
      endereco_escrita_r <= '0;
      dado_escrita_r     <= '0;
      endereco_leitura_r <= '0;
      bloco_r            <= '0;
      pronto_r           <= 1'b0;
      ocupado_r          <= 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (solicitacao_de_escrita_na_memoria) begin
            endereco_escrita_r <= endereco_de_escrita_na_memoria;
            dado_escrita_r     <= bloco_a_ser_escrito_na_memoria;
            if (solicitacao_de_leitura_na_memoria) begin
              endereco_leitura_r <= tag_de_acesso_na_memoria;
              pendente_r         <= 1'b1;
            end
            contador_r <= RECARGA;
            ocupado_r  <= 1'b1;
            estado_r   <= ESCRITA;
          end else if (solicitacao_de_leitura_na_memoria) begin
            endereco_leitura_r <= tag_de_acesso_na_memoria;
            contador_r         <= RECARGA;
            ocupado_r          <= 1'b1;
            estado_r           <= LEITURA;
          end
        end
        ESCRITA: begin
          if (contador_r != 4'd0) begin
            contador_r <= contador_r - 4'd1;
          end else if (pendente_r) begin
            pendente_r <= 1'b0;
            contador_r <= RECARGA;
            estado_r   <= LEITURA;
          end else begin
            pronto_r <= 1'b1;
            estado_r <= RESPOSTA;
          end
        end
        LEITURA: begin
          if (contador_r != 4'd0) begin
            contador_r <= contador_r - 4'd1;
          end else begin
            bloco_r  <= dado_lido_s;
            pronto_r <= 1'b1;
            estado_r <= RESPOSTA;
          end
        end
        RESPOSTA: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          estado_r  <= OCIOSO;
        end
        default: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          estado_r  <= OCIOSO;
        end
      endcase
    end
  end

  assign bloco_lido_da_memoria = bloco_r;
  assign pronto                = pronto_r;
  assign ocupado               = ocupado_r;

endmodule

// File: tb/tb_memoria_principal.sv
// Scoreboard bench for memoria_principal: a reference memory predicts each pronto cycle and block.
module tb_memoria_principal;

  localparam int L = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [4:0] tag = 5'd0;
  logic [4:0] end_w = 5'd0;
  logic [7:0] dado_w = 8'h00;
  logic [7:0] bloco;
  logic       pronto;
  logic       ocupado;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [32];
  logic [7:0] ref_bloco;
  logic [7:0] exp_dado_q [$];
  int         exp_ciclo_q [$];

  memoria_principal #(.LATENCY(L), .ADDR_W(5), .DATA_W(8)) dut (
    .clock                            (clock),
    .reset                            (reset),
    .solicitacao_de_leitura_na_memoria(rd),
    .solicitacao_de_escrita_na_memoria(wr),
    .tag_de_acesso_na_memoria         (tag),
    .endereco_de_escrita_na_memoria   (end_w),
    .bloco_a_ser_escrito_na_memoria   (dado_w),
    .bloco_lido_da_memoria            (bloco),
    .pronto                           (pronto),
    .ocupado                          (ocupado)
  );

  always #5 clock = ~clock;

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i);
    ref_bloco = 8'h00;
  endtask

  // Predict one transaction and push its expected pronto cycle and block.
  task automatic prever(input logic r, input logic w, input logic [4:0] ra,
                        input logic [4:0] wa, input logic [7:0] wd);
    if (w) ref_mem[wa] = wd;
    if (r) ref_bloco = ref_mem[ra];
    exp_dado_q.push_back(ref_bloco);
    exp_ciclo_q.push_back((r && w) ? 2 * L + 1 : L + 1);
  endtask

  // Drive one request from an OCIOSO cycle and wait (bounded) for pronto; ciclo = -1 on timeout.
  task automatic acesso(input logic r, input logic w, input logic [4:0] ra,
                        input logic [4:0] wa, input logic [7:0] wd,
                        output int ciclo, output logic ocup_ok);
    rd = r; wr = w; tag = ra; end_w = wa; dado_w = wd;
    ciclo = -1;
    ocup_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (ocupado !== 1'b1) ocup_ok = 1'b0;
      if (pronto === 1'b1) begin
        ciclo = k;
        break;
      end
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    ref_reset();
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b0 || bloco !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: pronto=%b ocupado=%b bloco=%h, required 0 0 00", pronto, ocupado, bloco);
    end
  endtask

  task automatic test_leitura();
    int ciclo, ec; logic ok; logic [7:0] ed;
    prever(1'b1, 1'b0, 5'd5, 5'd0, 8'h00);
    acesso(1'b1, 1'b0, 5'd5, 5'd0, 8'h00, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec) begin errors++; $display("FAIL leitura_ciclo: got %0d, required %0d", ciclo, ec); end
    checks++;
    if (bloco !== ed) begin errors++; $display("FAIL leitura_dado: got %h, required %h", bloco, ed); end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL leitura_ocupado: ocupado low within cycles 1..%0d", ec); end
    @(posedge clock); #1;
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL leitura_fim: pronto=%b ocupado=%b, required 0 0", pronto, ocupado);
    end
  endtask

  task automatic test_escrita();
    int ciclo, ec; logic ok; logic [7:0] ed;
    prever(1'b0, 1'b1, 5'd0, 5'd9, 8'hA7);
    acesso(1'b0, 1'b1, 5'd0, 5'd9, 8'hA7, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec) begin errors++; $display("FAIL escrita_ciclo: got %0d, required %0d", ciclo, ec); end
    checks++;
    if (bloco !== ed) begin errors++; $display("FAIL escrita_bloco_mantido: got %h, required %h", bloco, ed); end
    @(posedge clock); #1;
    prever(1'b1, 1'b0, 5'd9, 5'd0, 8'h00);
    acesso(1'b1, 1'b0, 5'd9, 5'd0, 8'h00, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec || bloco !== ed) begin
      errors++; $display("FAIL escrita_releitura: cycle %0d data %h, required cycle %0d data %h", ciclo, bloco, ec, ed);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_combinado();
    int ciclo, ec; logic ok; logic [7:0] ed;
    prever(1'b1, 1'b1, 5'd2, 5'd2, 8'h3C);
    acesso(1'b1, 1'b1, 5'd2, 5'd2, 8'h3C, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec) begin errors++; $display("FAIL combinado_mesmo_ciclo: got %0d, required %0d", ciclo, ec); end
    checks++;
    if (bloco !== ed) begin errors++; $display("FAIL combinado_mesmo_dado: got %h, required %h", bloco, ed); end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL combinado_ocupado: ocupado low within cycles 1..%0d", ec); end
    @(posedge clock); #1;
    checks++;
    if (pronto !== 1'b0) begin errors++; $display("FAIL combinado_pulso_unico: pronto=%b, required 0", pronto); end
    prever(1'b1, 1'b1, 5'd0, 5'd31, 8'hFF);
    acesso(1'b1, 1'b1, 5'd0, 5'd31, 8'hFF, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec || bloco !== ed) begin
      errors++; $display("FAIL combinado_diferente: cycle %0d data %h, required cycle %0d data %h", ciclo, bloco, ec, ed);
    end
    @(posedge clock); #1;
    prever(1'b1, 1'b0, 5'd31, 5'd0, 8'h00);
    acesso(1'b1, 1'b0, 5'd31, 5'd0, 8'h00, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec || bloco !== ed) begin
      errors++; $display("FAIL combinado_releitura_31: cycle %0d data %h, required cycle %0d data %h", ciclo, bloco, ec, ed);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_meio();
    int ciclo, ec; logic ok; logic [7:0] ed; logic viu_pronto;
    wr = 1'b1; end_w = 5'd4; dado_w = 8'h55;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; wr = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b0 || bloco !== 8'h00) begin
      errors++; $display("FAIL reset_meio_saidas: pronto=%b ocupado=%b bloco=%h, required 0 0 00", pronto, ocupado, bloco);
    end
    reset = 1'b0;
    ref_reset();
    viu_pronto = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (pronto === 1'b1 || ocupado === 1'b1) viu_pronto = 1'b1;
    end
    checks++;
    if (viu_pronto !== 1'b0) begin errors++; $display("FAIL reset_meio_sem_pronto: activity seen=%b, required 0", viu_pronto); end
    prever(1'b1, 1'b0, 5'd4, 5'd0, 8'h00);
    acesso(1'b1, 1'b0, 5'd4, 5'd0, 8'h00, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec || bloco !== ed) begin
      errors++; $display("FAIL reset_meio_releitura: cycle %0d data %h, required cycle %0d data %h", ciclo, bloco, ec, ed);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int ciclo, ec; logic ok; logic [7:0] ed;
    prever(1'b1, 1'b0, 5'd5, 5'd0, 8'h00);
    prever(1'b1, 1'b0, 5'd5, 5'd0, 8'h00);
    rd = 1'b1; tag = 5'd5;
    ciclo = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (pronto === 1'b1) begin ciclo = k; break; end
    end
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec || bloco !== ed) begin
      errors++; $display("FAIL b2b_primeiro: cycle %0d data %h, required cycle %0d data %h", ciclo, bloco, ec, ed);
    end
    @(posedge clock); #1;
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++; $display("FAIL b2b_ocioso: ocupado=%b pronto=%b, required 0 0", ocupado, pronto);
    end
    @(posedge clock); #1;
    checks++;
    if (ocupado !== 1'b1) begin errors++; $display("FAIL b2b_aceito: ocupado=%b, required 1", ocupado); end
    wr = 1'b1; end_w = 5'd3; dado_w = 8'hEE; tag = 5'd7;
    @(posedge clock); #1;
    rd = 1'b0;
    @(posedge clock); #1;
    rd = 1'b1; wr = 1'b0; tag = 5'd5;
    ciclo = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (pronto === 1'b1) begin ciclo = k; break; end
    end
    rd = 1'b0;
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== 1 || bloco !== ed) begin
      errors++; $display("FAIL b2b_segundo: cycles after toggle %0d data %h, required 1 data %h", ciclo, bloco, ed);
    end
    @(posedge clock); #1;
    prever(1'b1, 1'b0, 5'd3, 5'd0, 8'h00);
    acesso(1'b1, 1'b0, 5'd3, 5'd0, 8'h00, ciclo, ok);
    ed = exp_dado_q.pop_front(); ec = exp_ciclo_q.pop_front();
    checks++;
    if (ciclo !== ec || bloco !== ed) begin
      errors++; $display("FAIL b2b_escrita_ignorada: cycle %0d data %h, required cycle %0d data %h", ciclo, bloco, ec, ed);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_leitura();
    test_escrita();
    test_combinado();
    test_reset_meio();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
